game_timebase: RTL and testbench
================================

Name: game_timebase

Overview:
- Timing and randomness source that feeds the reaction-game FSM.
- Generates a 1 ms tick from the system clock and runs a millisecond timer (count up or count down) under FSM control.
- Runs a 0..60 s game-clock and supplies a random LED index that is in range and never the same as the previous one.
- Sits directly upstream of the FSM. Its timer_value, game_timer_value and random_value outputs are the FSM's inputs of the same names.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick (50 MHz board clock).
- MAX_MS, 2047, millisecond timer saturation value.
- MIN_DELAY_MS, 500, minimum random countdown delay.
- DELAY_SPAN_LOG2, 10, random delay offset range is 0..2^DELAY_SPAN_LOG2-1 ms.
- GAME_SECONDS, 60, game-clock terminal value.
- LED_NUM, 18, number of target LEDs; random_value is in 0..LED_NUM-1.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- ms_clear, input, 1, synchronous clear/load of the ms timer.
- ms_countdown, input, 1, 1 = countdown mode (clear loads a random delay); 0 = count-up mode (clear loads 0).
- ms_enable, input, 1, ms timer advances on a tick while high.
- game_clear, input, 1, synchronous clear of the game-clock and its seconds prescaler.
- game_enable, input, 1, game-clock advances while high.
- rand_req, input, 1, single-cycle request for a new random LED index.
- ms_tick, output, 1, one-cycle pulse every CLKS_PER_MS cycles.
- timer_value, output, $clog2(MAX_MS), millisecond timer.
- game_timer_value, output, $clog2(GAME_SECONDS), elapsed game seconds.
- random_value, output, $clog2(LED_NUM), current target LED index.
- random_valid, output, 1, 1 when random_value is settled.

Behaviour:

Reset (asynchronous, on assertion):
- ms_tick=0, timer_value=0, game_timer_value=0, random_value=0, random_valid=1.
- Prescalers = 0, lfsr=LFSR_SEED, rand state IDLE.
- Reset mid-operation aborts any pending search, countdown or game.

Tick prescaler:
- Free-running counter 0..CLKS_PER_MS-1, not gated by any enable.
- ms_tick is registered and high for the single cycle after the counter wraps. The first tick comes CLKS_PER_MS cycles after reset release.

LFSR:
- 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
- Steps every clock, never reaches 0.

ms timer priority (highest first):
- ms_clear: timer_value <= ms_countdown ? MIN_DELAY_MS + lfsr[DELAY_SPAN_LOG2-1:0] : 0. The sum saturates at MAX_MS.
- Otherwise, ms_enable & ms_tick:
  - countdown mode: decrement, holding at 0.
  - count-up mode: increment, holding at MAX_MS.
- Otherwise: hold.
- Clear wins over a same-cycle tick.
- Countdown/count-up direction is sampled each tick; changing it mid-count takes effect at the next tick.

Game-clock:
- game_clear: game_timer_value <= 0, seconds prescaler <= 0. Clear wins over a same-cycle tick.
- Otherwise, if game_enable & ms_tick: the seconds prescaler counts 0..999. On 999->0, game_timer_value increments, saturating at GAME_SECONDS.
- game_enable low freezes both the prescaler and game_timer_value.

Random index FSM:
- IDLE: random_valid=1. On rand_req go to SEARCH: random_valid<=0, attempt counter <= 0.
- SEARCH, each cycle:
  - Candidate c = lfsr[4:0].
  - Accept if c < LED_NUM and c != random_value: random_value<=c, random_valid<=1, go to IDLE.
  - Otherwise increment the attempt counter.
  - After 32 rejected attempts, force random_value <= (random_value+1 == LED_NUM) ? 0 : random_value+1, random_valid<=1, go to IDLE.
- Worst-case latency: 33 cycles from rand_req to random_valid. random_value never changes while random_valid=1.
- rand_req while in SEARCH is ignored; no queuing.
- LED_NUM=1: always force 0 (degenerate case; no distinct index exists).

Width rules:
- All counters are unsigned.
- The delay sum is computed one bit wider than timer_value, then saturated.

Test Plan:
- CLKS_PER_MS=4, release reset, hold all controls low -> ms_tick high on cycles 4, 8, 12 after release; all outputs stay at reset values.
- ms_countdown=0, pulse ms_clear, then ms_enable=1 for 2050 ticks -> timer_value counts 0,1,2,…, holds at 2047; ms_clear on a tick cycle -> 0 next cycle.
- ms_countdown=1, pulse ms_clear with lfsr forced so lfsr[9:0]=10'd100 -> timer_value=600; with enable it reaches 0 after 600 ticks and holds at 0.
- game_enable=1, CLKS_PER_MS=4 -> game_timer_value=1 after 4000 cycles, reaches 60 at 240000 cycles and holds. game_enable=0 for 500 ticks -> frozen. game_clear -> 0.
- 1000 rand_req pulses spaced 40 cycles apart -> every random_value < 18, no two consecutive values equal, random_valid low for 1..33 cycles per request.
- Assert reset during SEARCH and during a countdown at timer_value=300 -> next cycle random_valid=1, random_value=0, timer_value=0, lfsr=16'hACE1.

Source files
------------

// File: rtl/game_timebase.sv
// Timing and randomness source for the reaction-game FSM: 1 ms tick, ms timer,
// seconds game-clock and a non-repeating random LED index.
module game_timebase #(
  parameter int          CLKS_PER_MS     = 50000,
  parameter int          MAX_MS          = 2047,
  parameter int          MIN_DELAY_MS    = 500,
  parameter int          DELAY_SPAN_LOG2 = 10,
  parameter int          GAME_SECONDS    = 60,
  parameter int          LED_NUM         = 18,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  localparam int         TW              = $clog2(MAX_MS),
  localparam int         GW              = $clog2(GAME_SECONDS),
  localparam int         RW              = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ms_clear,
  input  logic          ms_countdown,
  input  logic          ms_enable,
  input  logic          game_clear,
  input  logic          game_enable,
  input  logic          rand_req,
  output logic          ms_tick,
  output logic [TW-1:0] timer_value,
  output logic [GW-1:0] game_timer_value,
  output logic [RW-1:0] random_value,
  output logic          random_valid
);

  localparam int              PW        = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(CLKS_PER_MS - 1);
  localparam int              SW        = TW + 1;
  localparam logic [SW-1:0]   SUM_MAX   = SW'(MAX_MS);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(MAX_MS);
  localparam logic [GW-1:0]   GAME_MAX  = GW'(GAME_SECONDS);
  localparam logic [RW-1:0]   LAST_IDX  = RW'(LED_NUM - 1);
  localparam logic [5:0]      LED_LIM   = 6'(LED_NUM);

  typedef enum logic {IDLE, SEARCH} rand_state_t;

  logic [PW-1:0] tick_cnt;
  logic [15:0]   lfsr;
  logic [9:0]    sec_cnt;
  logic [4:0]    attempts;
  rand_state_t   rand_state;

  logic [SW-1:0] delay_sum;
  logic [TW-1:0] delay_load;
  logic [4:0]    cand;
  logic          cand_ok;
  logic          force_next;
  logic [RW-1:0] next_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      ms_tick  <= 1'b0;
    end else begin
      ms_tick  <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // The delay sum carries one extra bit so saturation can be detected.
  always_comb begin
    delay_sum  = SW'(MIN_DELAY_MS) + SW'(lfsr[DELAY_SPAN_LOG2-1:0]);
    delay_load = (delay_sum > SUM_MAX) ? TIMER_MAX : delay_sum[TW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_value <= '0;
    end else if (ms_clear) begin
      timer_value <= ms_countdown ? delay_load : '0;
    end else if (ms_enable && ms_tick) begin
      if (ms_countdown) begin
        if (timer_value != '0) timer_value <= timer_value - 1'b1;
      end else if (timer_value != TIMER_MAX) begin
        timer_value <= timer_value + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt          <= '0;
      game_timer_value <= '0;
    end else if (game_clear) begin
      sec_cnt          <= '0;
      game_timer_value <= '0;
    end else if (game_enable && ms_tick) begin
      if (sec_cnt == 10'd999) begin
        sec_cnt <= '0;
        if (game_timer_value != GAME_MAX) game_timer_value <= game_timer_value + 1'b1;
      end else begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

  // With a single LED no distinct index exists, so the search gives up at once.
  always_comb begin
    cand       = lfsr[4:0];
    cand_ok    = (LED_NUM > 1) && ({1'b0, cand} < LED_LIM) && (6'(cand) != 6'(random_value));
    force_next = (attempts == 5'd31) || (LED_NUM == 1);
    next_idx   = (random_value == LAST_IDX) ? '0 : random_value + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rand_state   <= IDLE;
      random_value <= '0;
      random_valid <= 1'b1;
      attempts     <= '0;
    end else begin
      case (rand_state)
        IDLE: begin
          if (rand_req) begin
            rand_state   <= SEARCH;
            random_valid <= 1'b0;
            attempts     <= '0;
          end
        end
        SEARCH: begin
          if (cand_ok) begin
            random_value <= RW'(cand);
            random_valid <= 1'b1;
            rand_state   <= IDLE;
          end else if (force_next) begin
            random_value <= next_idx;
            random_valid <= 1'b1;
            rand_state   <= IDLE;
          end else begin
            attempts <= attempts + 1'b1;
          end
        end
        default: rand_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_timebase.sv
// Scoreboard bench for game_timebase: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_timebase;

  localparam int CLKS  = 4;
  localparam int MAXMS = 2047;
  localparam int MIND  = 500;
  localparam int GSEC  = 3;
  localparam int LEDS  = 18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ms_clear = 1'b0, ms_countdown = 1'b0, ms_enable = 1'b0;
  logic        game_clear = 1'b0, game_enable = 1'b0, rand_req = 1'b0;
  logic        ms_tick;
  logic [10:0] timer_value;
  logic [1:0]  game_timer_value;
  logic [4:0]  random_value;
  logic        random_valid;

  game_timebase #(
    .CLKS_PER_MS(CLKS), .MAX_MS(MAXMS), .MIN_DELAY_MS(MIND), .DELAY_SPAN_LOG2(10),
    .GAME_SECONDS(GSEC), .LED_NUM(LEDS), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .ms_clear(ms_clear), .ms_countdown(ms_countdown),
    .ms_enable(ms_enable), .game_clear(game_clear), .game_enable(game_enable),
    .rand_req(rand_req), .ms_tick(ms_tick), .timer_value(timer_value),
    .game_timer_value(game_timer_value), .random_value(random_value),
    .random_valid(random_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int sel; int val; } exp_t;
  typedef struct { int val; int low; } rexp_t;
  exp_t  sb_q[$];
  rexp_t rand_q[$];

  int tests = 0;
  int fails = 0;
  int cyc;
  logic [15:0] m_lfsr;
  int m_rv = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference cycle counter and LFSR, both restarted by reset like the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc    <= 0;
      m_lfsr <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Number of ms_tick cycles in [a, b]; ticks sit on multiples of CLKS.
  function automatic int nt(input int a, input int b);
    if (b < a) return 0;
    return b / CLKS - (a - 1) / CLKS;
  endfunction

  function automatic int cd_val(input int d, input int c, input int t);
    int v;
    v = d - nt(c + 1, t - 1);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic string sel_name(input int s);
    case (s)
      0: return "ms_tick";
      1: return "timer_value";
      2: return "game_timer_value";
      3: return "random_value";
      default: return "random_valid";
    endcase
  endfunction

  function automatic int get_out(input int s);
    case (s)
      0: return int'(ms_tick);
      1: return int'(timer_value);
      2: return int'(game_timer_value);
      3: return int'(random_value);
      default: return int'(random_valid);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkAt(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c; e.sel = s; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic clr, input logic cd, input logic en,
                               input logic gclr, input logic gen, input logic rreq);
    ms_clear = clr; ms_countdown = cd; ms_enable = en;
    game_clear = gclr; game_enable = gen; rand_req = rreq;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while ((sb_q.size() != 0 || rand_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || rand_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d entries pending, expected 0", sb_q.size() + rand_q.size());
      sb_q.delete();
      rand_q.delete();
    end
    @(negedge clk);
  endtask

  // Predicts the index and low-time of a request issued in the current cycle.
  task automatic requestRandom();
    logic [15:0] l;
    rexp_t r;
    int c;
    l = m_lfsr;
    r.val = -1;
    r.low = 0;
    for (int k = 1; k <= 32; k++) begin
      l = lfsr_step(l);
      c = int'(l[4:0]);
      if (c < LEDS && c != m_rv) begin
        r.val = c; r.low = k;
        break;
      end
      if (k == 32) begin
        r.val = (m_rv + 1 == LEDS) ? 0 : m_rv + 1;
        r.low = 32;
      end
    end
    m_rv = r.val;
    rand_q.push_back(r);
    rand_req = 1'b1;
    @(negedge clk);
    rand_req = 1'b0;
  endtask

  exp_t  mon_e;
  rexp_t mon_r;
  bit    prev_valid = 1'b1;
  int    low_cnt = 0;
  bit    rand_to = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_ms_tick", int'(ms_tick), 0);
      checkOutput("rst_timer_value", int'(timer_value), 0);
      checkOutput("rst_game_timer_value", int'(game_timer_value), 0);
      checkOutput("rst_random_value", int'(random_value), 0);
      checkOutput("rst_random_valid", int'(random_valid), 1);
      prev_valid = 1'b1;
      low_cnt    = 0;
      rand_to    = 1'b0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        mon_e = sb_q.pop_front();
        if (mon_e.cyc < cyc) begin
          tests++;
          fails++;
          $display("[TB] FAIL missed %s check: cycle %0d passed, now %0d", sel_name(mon_e.sel), mon_e.cyc, cyc);
        end else begin
          checkOutput(sel_name(mon_e.sel), get_out(mon_e.sel), mon_e.val);
        end
      end
      if (!random_valid) begin
        low_cnt++;
        if (low_cnt > 40 && !rand_to) begin
          rand_to = 1'b1;
          checkOutput("random_valid_timeout", low_cnt, 33);
        end
      end else if (!prev_valid) begin
        if (rand_q.size() == 0) begin
          checkOutput("unexpected_random_valid", 1, 0);
        end else begin
          mon_r = rand_q.pop_front();
          checkOutput("random_value", int'(random_value), mon_r.val);
          checkOutput("random_latency", low_cnt, mon_r.low);
        end
        low_cnt = 0;
      end
      prev_valid = random_valid;
    end
  end

  initial begin
    #1500000;
    tests++;
    fails++;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : stim
    int C, d, f, F, G, H, T, n1;
    int up_offs[10];
    int dn_offs[7];
    int g_offs[8];

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Idle outputs and the free-running tick.
    for (int t = 1; t <= 12; t++) begin
      checkAt(t, 0, (t % CLKS == 0) ? 1 : 0);
      checkAt(t, 1, 0);
      checkAt(t, 2, 0);
      checkAt(t, 3, 0);
      checkAt(t, 4, 1);
    end
    waitDrain(100);

    // Count-up to saturation.
    C = cyc;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkAt(C + 1, 1, 0);
    up_offs = '{2, 5, 9, 40, 401, 8185, 8189, 8193, 8200, 8300};
    foreach (up_offs[i]) checkAt(C + up_offs[i], 1, imin(nt(C + 1, C + up_offs[i] - 1), MAXMS));
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 0, 0);
    waitDrain(20000);

    // Clear on a tick cycle beats the increment.
    while (cyc % CLKS != 0) @(negedge clk);
    T = cyc;
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkAt(T + 1, 1, 0);
    checkAt(T + 5, 1, 1);
    checkAt(T + 9, 1, 2);
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 0, 0);
    waitDrain(100);

    // Countdown from a random delay down to zero.
    C = cyc;
    d = imin(MIND + int'(m_lfsr[9:0]), MAXMS);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkAt(C + 1, 1, d);
    dn_offs = '{2, 10, 100, 4 * d - 3, 4 * d + 1, 4 * d + 9, 4 * d + 200};
    foreach (dn_offs[i]) checkAt(C + dn_offs[i], 1, cd_val(d, C, C + dn_offs[i]));
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0, 0);
    waitDrain(20000);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Game clock: first second, freeze, resume, saturate, clear.
    C = cyc;
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkAt(C + 1, 2, 0);
    f  = ((C + 1 + CLKS - 1) / CLKS) * CLKS;
    F  = f + 3996 + 1202;
    G  = F + 2000;
    n1 = nt(C + 1, F - 1);
    checkAt(f + 3996, 2, imin(nt(C + 1, f + 3995) / 1000, GSEC));
    checkAt(f + 3997, 2, imin(nt(C + 1, f + 3996) / 1000, GSEC));
    checkAt(F + 1000, 2, imin(n1 / 1000, GSEC));
    checkAt(F + 1999, 2, imin(n1 / 1000, GSEC));
    g_offs = '{1000, 2000, 2780, 2800, 2820, 6780, 6820, 11000};
    foreach (g_offs[i]) checkAt(G + g_offs[i], 2, imin((n1 + nt(G, G + g_offs[i] - 1)) / 1000, GSEC));
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 0);
    waitUntil(F);
    applyStimulus(0, 0, 0, 0, 0, 0);
    waitUntil(G);
    applyStimulus(0, 0, 0, 0, 1, 0);
    waitUntil(G + 11000);
    H = cyc;
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkAt(H + 1, 2, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    waitDrain(100);

    // Random index requests.
    for (int i = 0; i < 250; i++) begin
      requestRandom();
      repeat (38) @(negedge clk);
    end
    waitDrain(100);

    // Reset during a countdown at 300 with a search in flight.
    C = cyc;
    d = imin(MIND + int'(m_lfsr[9:0]), MAXMS);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkAt(C + 1, 1, d);
    T = C + 2;
    while (cd_val(d, C, T) != 300) T++;
    checkAt(T, 1, 300);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0, 0);
    waitUntil(T - 1);
    applyStimulus(0, 1, 1, 0, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    m_rv = 0;
    checkAt(1, 1, 0);
    checkAt(1, 3, 0);
    checkAt(1, 4, 1);

    // LFSR restarted from the seed: the loaded delay and next index follow it.
    waitUntil(2);
    d = imin(MIND + int'(m_lfsr[9:0]), MAXMS);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkAt(3, 1, d);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    requestRandom();
    waitDrain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
